// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame controller for the UART transmit path. Accepts bytes
// through a valid/ready handshake into a one-entry holding buffer, hands each
// byte to the downstream serializer and sequences start, data, optional parity
// and stop bits onto the serial line. One clk period is one bit time.
//
// Build option: define UART_TX_PARITY_EN to include the parity bit (11-bit
// frame, par_typ selects even/odd). Left undefined, the frame is 10 bits and
// par_typ is ignored.
//
// Ports:
//   clk        in   bit clock, rising edge
//   rst        in   asynchronous active-low reset
//   p_data     in   byte to transmit, sampled on an accepted transfer
//   data_valid in   upstream has a byte
//   data_ready out  holding buffer is empty
//   par_typ    in   parity type: 0 = even, 1 = odd
//   ser_p_data out  frame register for the serializer's parallel input
//   ser_en     out  serializer load/shift enable
//   ser_data   in   current data bit from the serializer
//   ser_done   in   serializer is presenting its last data bit
//   tx_out     out  serial line, idles high
//   busy       out  high whenever the controller is not idle
module uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] p_data,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              par_typ,
  output logic [DATA_W-1:0] ser_p_data,
  output logic              ser_en,
  input  logic              ser_data,
  input  logic              ser_done,
  output logic              tx_out,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_POST_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_POST_DATA = ST_STOP;
`endif

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(DATA_W - 1);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              move;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`else
  logic              par_typ_unused;
  assign par_typ_unused = par_typ;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding buffer, frame register, watchdog and parity latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q   <= '0;
      full_q  <= 1'b0;
      frame_q <= '0;
      cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      buf_q   <= buf_d;
      full_q  <= full_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    full_d  = full_q;
    frame_d = frame_q;
    cnt_d   = '0;
    move    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Writes only land in an empty buffer, moves only drain a full one,
    // so the two can never coincide.
    if (data_valid && !full_q) begin
      buf_d  = p_data;
      full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (full_q) begin
          state_d = ST_START;
          move    = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        // Watchdog bounds DATA to DATA_W cycles if ser_done never arrives.
        cnt_d = cnt_q + CNT_W'(1);
        if (ser_done || (cnt_q == WDOG_LAST)) begin
          state_d = ST_POST_DATA;
          cnt_d   = '0;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (full_q) begin
          state_d = ST_START;
          move    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (move) begin
      frame_d = buf_q;
      full_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_typ;
`endif
    end
  end

  // Line and serializer-enable decode from the state register
  always_comb begin
    tx_out = 1'b1;
    ser_en = 1'b0;
    case (state_q)
      ST_START: begin
        tx_out = 1'b0;
        ser_en = 1'b1;
      end
      ST_DATA: begin
        tx_out = ser_data;
        ser_en = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_out = (^frame_q) ^ par_q;
      end
`endif
      default: begin
        tx_out = 1'b1;
      end
    endcase
  end

  assign data_ready = !full_q;
  assign busy       = (state_q != ST_IDLE);
  assign ser_p_data = frame_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl. Includes a behavioural
// serializer (LSB first) and a monitor that compares the line per bit time
// against frames predicted from each accepted byte.
module tb_uart_tx_ctrl;

  localparam int unsigned DATA_W = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_LEN = DATA_W + 3;
`else
  localparam int unsigned FRAME_LEN = DATA_W + 2;
`endif

  typedef struct packed {
    logic tx;
    logic en;
    logic first;
  } bit_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] p_data;
  logic              data_valid;
  logic              data_ready;
  logic              par_typ;
  logic [DATA_W-1:0] ser_p_data;
  logic              ser_en;
  logic              ser_data;
  logic              ser_done;
  logic              tx_out;
  logic              busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_edge = -10;
  int   busy_cycles = 0;
  bit_t exp_q[$];

  logic              done_en  = 1'b1;
  logic              noise_en = 1'b0;
  logic              noise    = 1'b0;
  logic [DATA_W-1:0] sh;
  logic [3:0]        idx;
  logic              loaded;

  uart_tx_ctrl #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .par_typ    (par_typ),
    .ser_p_data (ser_p_data),
    .ser_en     (ser_en),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural serializer: loads on the first enabled cycle, then shifts LSB first.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaded <= 1'b0;
      idx    <= '0;
      sh     <= '0;
    end else if (ser_en) begin
      if (!loaded) begin
        sh     <= ser_p_data;
        idx    <= '0;
        loaded <= 1'b1;
      end else begin
        idx <= idx + 4'd1;
      end
    end else begin
      loaded <= 1'b0;
    end
  end

  assign ser_data = sh[idx[2:0]];
  // Real done only on the last data bit; random pulses elsewhere when noise is on.
  assign ser_done = (loaded && idx < 4'd8) ? (done_en && idx == 4'd7) : noise;

  always begin
    @(posedge clk);
    #2;
    noise = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference frame: start, data LSB first, optional parity, stop.
  function automatic void push_frame(input logic [DATA_W-1:0] b, input logic pt);
    int ones = 0;
    exp_q.push_back('{tx: 1'b0, en: 1'b1, first: 1'b1});
    for (int i = 0; i < int'(DATA_W); i++) begin
      exp_q.push_back('{tx: b[i], en: 1'b1, first: 1'b0});
      if (b[i]) ones++;
    end
`ifdef UART_TX_PARITY_EN
    // Parity bit makes the total count of ones even (pt=0) or odd (pt=1).
    exp_q.push_back('{tx: 1'((ones % 2) != int'(pt)), en: 1'b0, first: 1'b0});
`endif
    exp_q.push_back('{tx: 1'b1, en: 1'b0, first: 1'b0});
  endfunction

  // Monitor: one expected bit per busy cycle; idle must hold the line high.
  always @(negedge clk) begin
    bit_t it;
    if (rst === 1'b1) begin
      if (busy) begin
        busy_cycles++;
        if (exp_q.size() == 0) begin
          check("busy_without_frame", 32'(busy), 32'd0);
        end else begin
          it = exp_q.pop_front();
          check("tx_bit", 32'(tx_out), 32'(it.tx));
          check("ser_en", 32'(ser_en), 32'(it.en));
          if (it.first) check("ready_at_start", 32'(data_ready), 32'd1);
        end
      end else begin
        check("idle_tx", 32'(tx_out), 32'd1);
        check("idle_ser_en", 32'(ser_en), 32'd0);
        if (exp_q.size() != 0) begin
          check("idle_gap", 32'((exp_q.size() == FRAME_LEN) &&
                                ((cyc == acc_edge - 1) || (cyc == acc_edge))), 32'd1);
          if (cyc == acc_edge) check("ready_after_accept", 32'(data_ready), 32'd0);
        end else begin
          check("idle_ready", 32'(data_ready), 32'd1);
        end
      end
    end
  end

  // Offer a byte at posedge+1; the transfer happens at the following edge.
  task automatic offer(input logic [DATA_W-1:0] b, input logic pt);
    int waitc = 0;
    p_data     = b;
    par_typ    = pt;
    data_valid = 1'b1;
    while (!data_ready) begin
      @(posedge clk);
      #1;
      waitc++;
      if (waitc > 100) begin
        check("offer_timeout", 32'd1, 32'd0);
        data_valid = 1'b0;
        return;
      end
    end
    push_frame(b, pt);
    acc_edge = cyc + 1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waitc = 0;
    while (busy || exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      waitc++;
      if (waitc > 200) begin
        check("idle_timeout", 32'd1, 32'd0);
        exp_q.delete();
        return;
      end
    end
  endtask

  initial begin
    int b0;
    int e0;
    rst        = 1'b0;
    data_valid = 1'b0;
    p_data     = '0;
    par_typ    = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_data_ready", 32'(data_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ser_en", 32'(ser_en), 32'd0);
    check("rst_ser_p_data", 32'(ser_p_data), 32'd0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single frames with parity corner cases
    b0 = busy_cycles;
    offer(8'hA5, 1'b0);
    wait_idle();
    check("single_busy_len", 32'(busy_cycles - b0), 32'(FRAME_LEN));
    offer(8'h01, 1'b1);
    wait_idle();
    offer(8'h00, 1'b1);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back with data_valid held
    b0 = busy_cycles;
    offer(8'h55, 1'b0);
    e0 = acc_edge;
    offer(8'h0F, 1'b0);
    check("b2b_accept_edge", 32'(acc_edge - e0), 32'd2);
    wait_idle();
    check("b2b_busy_len", 32'(busy_cycles - b0), 32'(2 * FRAME_LEN));

    // Reset during the 4th data bit with a second byte buffered
    offer(8'h3C, 1'b0);
    offer(8'hC3, 1'b0);
    check("pre_rst_full", 32'(data_ready), 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_tx_out", 32'(tx_out), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ser_en", 32'(ser_en), 32'd0);
    check("midrst_ready", 32'(data_ready), 32'd1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    b0 = busy_cycles;
    repeat (25) @(posedge clk);
    #1;
    check("post_rst_silent", 32'(busy_cycles - b0), 32'd0);

    // Watchdog: serializer never reports done
    done_en = 1'b0;
    b0 = busy_cycles;
    offer(8'h96, 1'b1);
    wait_idle();
    check("wdog_busy_len", 32'(busy_cycles - b0), 32'(FRAME_LEN));
    done_en = 1'b1;

    // Randomized streams with stray ser_done pulses outside DATA
    noise_en = 1'b1;
    for (int bt = 0; bt < 6; bt++) begin
      logic pt;
      int   nb;
      pt      = 1'($urandom_range(0, 1));
      done_en = (bt % 3 != 2);
      nb      = 4 + int'($urandom_range(0, 4));
      for (int j = 0; j < nb; j++) begin
        offer(DATA_W'($urandom_range(0, 255)), pt);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      wait_idle();
    end
    noise_en = 1'b0;
    done_en  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    check("end_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller for the UART transmit path, sitting directly upstream of the serializer. It accepts bytes through a valid/ready handshake into a one-entry holding buffer and sequences the start bit, the data bits (shifted out by the serializer), an optional parity bit and the stop bit. It multiplexes the final `tx_out` line. One `clk` period equals one bit time; baud generation is outside this block.

## Interface
Parameters:
- `DATA_W`, 8: byte width. Must match the serializer width.

Ports:
- `clk` in 1: bit clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `p_data` in DATA_W: byte to transmit, sampled on an accepted transfer.
- `data_valid` in 1: upstream has a byte.
- `data_ready` out 1: holding buffer is empty. A transfer occurs when `data_valid && data_ready` at a rising edge.
- `par_typ` in 1: selects the parity type. 0 = even, 1 = odd. Ignored when parity is compiled out.
- `ser_p_data` out DATA_W: frame register driven to the serializer's parallel input.
- `ser_en` out 1: serializer load/shift enable.
- `ser_data` in 1: current data bit from the serializer.
- `ser_done` in 1: serializer is presenting its last data bit.
- `tx_out` out 1: serial line. Idle level is high.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Reset values:** state IDLE, buffer empty, `data_ready`=1, `ser_en`=0, `ser_p_data`=0, `tx_out`=1, `busy`=0. Parity latch is 0.
- **Holding buffer:** one entry. An accepted transfer writes `p_data` and sets the full flag. `data_ready` is the inverse of the full flag.
- **IDLE:**
  - `tx_out`=1.
  - If the buffer is full, go to START.
  - On entry to START: buffer moves to `ser_p_data`, the full flag clears, and `par_typ` is latched.
- **START:**
  - `tx_out`=0 and `ser_en`=1, so the serializer loads `ser_p_data`.
  - Next state is DATA.
- **DATA:**
  - `tx_out`=`ser_data` and `ser_en`=1.
  - Stay until `ser_done`=1 is sampled. That cycle is the last data bit.
  - Then go to PARITY, or to STOP when parity is compiled out.
- **Watchdog in DATA:** an internal 4-bit counter forces an exit to the next state after DATA_W cycles even if `ser_done` never asserts.
- **PARITY:**
  - `tx_out` = XOR-reduce of `ser_p_data`, XORed with the latched `par_typ`. Even parity gives an even total count of ones; odd parity gives an odd total.
  - `ser_en`=0. Next state is STOP.
- **STOP:**
  - `tx_out`=1 and `ser_en`=0.
  - If the buffer is full, go to START (back-to-back, no idle bit) and perform the same buffer move. Otherwise go to IDLE.
- **Bit order** within DATA is owned by the serializer. This block does not reorder.
- **Output decoding:** `tx_out` is decoded combinationally from the state register and `ser_data`.

## Timing
- **Accept latency:** transfer at edge k. At edge k+1 the state is START and `tx_out` falls.
- **Buffer timing:** `data_ready` is 0 from edge k to edge k+1 and returns to 1 from edge k+1.
- **Frame length:** 1 + DATA_W + 1 + 1 = 11 cycles with parity, 10 without.
- **Continuous streaming:** a byte accepted at any time before the STOP edge produces zero idle cycles between frames.
- **No simultaneous buffer conflict:** a buffer move only happens while the buffer is full, when `data_ready`=0. A write and a move therefore never occur on the same edge.
- **Skipped bytes:** `p_data` is not sampled when `data_ready`=0. The upstream must hold `data_valid` and `p_data` until the transfer completes.
- **Async reset mid-frame:** the state returns to IDLE immediately and `tx_out` returns to 1. The buffered byte and the in-flight byte are discarded, and `ser_en` drops immediately.
- **Early `ser_done`:** a `ser_done` pulse outside DATA is ignored.

## Configuration
- **`UART_TX_PARITY_EN` defined:** the PARITY state exists, the frame is 11 bits, and `par_typ` selects even or odd parity.
- **`UART_TX_PARITY_EN` undefined:**
  - The PARITY state and parity logic are removed.
  - DATA goes directly to STOP, and the frame is 10 bits.
  - The `par_typ` port remains but is unused.

## Test plan
- **Reset:** `rst`=0 for 3 cycles, then release. Required: `tx_out`=1, `data_ready`=1, `busy`=0, `ser_en`=0.
- **Single even-parity frame:** `p_data`=0xA5, `par_typ`=0, parity enabled. Required: `tx_out`=0, then 8 serializer bits, then parity 0, then stop 1. `busy` is high for 11 cycles and the state then returns to IDLE.
- **Odd parity:** `p_data`=0x01, `par_typ`=1. Required: parity bit = 0. Also run `p_data`=0x00 with `par_typ`=1; required: parity bit = 1.
- **Back-to-back:** 0x55 and 0x0F are offered with `data_valid` held. Required:
  - The second byte is accepted one cycle after the first moves out.
  - `tx_out` goes from stop=1 straight to start=0 with no idle cycle.
  - 22 busy cycles in total.
- **Reset mid-DATA:** assert `rst` during the 4th data bit while a second byte is buffered. Required:
  - `tx_out` goes to 1 immediately, with the buffer empty.
  - After release, nothing is transmitted.
- **Watchdog, no parity build:** tie `ser_done`=0 with `UART_TX_PARITY_EN` undefined. Required: DATA exits after 8 cycles, the STOP bit is driven, and the frame is 10 cycles.
